keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles each column is driven (dwell); legal range >= 4.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive identical full-scan results required to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 row_in  input  4  keypad row lines, active-low (pulled up externally), asynchronous to clk.
REQ-006 col_out  output  4  keypad column drive, exactly one bit low at a time (one-hot-low).
REQ-007 key_coord  output  8  {row_val, col_val} of the accepted key, each nibble one-hot-low (e.g. row0/col0 = 8'b1110_1110, row3/col1 = 8'b0111_1101); 8'hFF when no key is accepted.
REQ-008 key_valid  output  1  one-cycle pulse marking a newly accepted press.
REQ-009 key_held  output  1  high while an accepted key is considered pressed.

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer before any use; synchronizer flops SHALL reset to 4'hF.
REQ-011 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, col_out SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-012 Synchronized rows SHALL be sampled only in the cycle where dwell counter = SCAN_DIV-1 (settled), into the capture slot of the current column.
REQ-013 After the column 0111 sample, a full-scan result SHALL be formed: exactly one low row bit in exactly one column -> code {row bits, col_out value of that column}; no low bit anywhere -> NONE (8'hFF); any other pattern -> MULTI.
REQ-014 A MULTI result SHALL be discarded: debounce counter and FSM state unchanged.
REQ-015 FSM states: IDLE, PRESS_DB, PRESSED, RELEASE_DB; state update only on full-scan-result cycles.
REQ-016 IDLE: code result -> PRESS_DB, candidate <= code, count <= 1; NONE -> stay.
REQ-017 PRESS_DB: result = candidate -> count+1; when count reaches DEBOUNCE_SCANS -> PRESSED; different code -> candidate <= new code, count <= 1; NONE -> IDLE.
REQ-018 Entering PRESSED SHALL load key_coord <= candidate and assert key_valid for exactly one clk cycle.
REQ-019 PRESSED: NONE or a different code -> RELEASE_DB, count <= 1; same code -> stay.
REQ-020 RELEASE_DB: NONE or different code -> count+1; when count reaches DEBOUNCE_SCANS -> IDLE, key_coord <= 8'hFF; same code as key_coord -> back to PRESSED without a key_valid pulse.
REQ-021 key_held SHALL be 1 in PRESSED and RELEASE_DB, 0 otherwise.
REQ-022 With DEBOUNCE_SCANS = 1, press acceptance occurs on the first full-scan result showing the code (IDLE -> PRESS_DB -> PRESSED collapses into one transition; still one key_valid pulse).
REQ-023 A new key SHALL be accepted only after passing through IDLE; sliding from one key to another produces release then press, two separate key_valid pulses.
REQ-024 Press latency: key_valid SHALL rise no later than (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles after a stable press begins.

Reset
REQ-025 While rst_n = 0 at a clk edge: col_out <= 4'b1110, dwell counter <= 0, capture slots <= 4'hF, FSM <= IDLE, count <= 0, key_coord <= 8'hFF, key_valid <= 0, key_held <= 0.
REQ-026 Reset asserted mid-debounce or mid-press SHALL discard all progress; no key_valid pulse for a key held through reset until it passes full press debounce afterwards.

Verification
REQ-027 SCAN_DIV=4, DEBOUNCE_SCANS=2; press row0/col0 (row_in bit0 low while col_out=1110) held -> single key_valid pulse, key_coord = 8'hEE, key_held = 1.
REQ-028 Same params; release after acceptance -> key_coord returns to 8'hFF and key_held falls after 2 NONE scans; no key_valid.
REQ-029 Bounce: press row3/col1 for 1 scan, NONE 1 scan, then stable -> exactly one key_valid, key_coord = 8'h7D.
REQ-030 Two keys (row0/col0 and row1/col2) simultaneously from IDLE -> MULTI every scan, no key_valid, key_coord stays 8'hFF.
REQ-031 Press row3/col3 accepted (8'h77), rst_n low 1 cycle, key still held -> outputs at reset values, then one new key_valid after debounce.
REQ-032 Check col_out is always one-hot-low and rotates every SCAN_DIV cycles across the run.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-hot-low column drive, captures the
// settled rows per column, and debounces whole-scan results into press/release events.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] key_coord,
  output logic       key_valid,
  output logic       key_held
);

  localparam int               CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DB_N      = 4'(DEBOUNCE_SCANS);
  localparam logic [7:0]       NO_KEY    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } state_t;

  logic [3:0]       row_meta_q;
  logic [3:0]       row_sync_q;
  logic [CNT_W-1:0] dwell_q;
  logic [3:0]       col_q;
  logic [3:0]       cap_q [4];
  logic             scan_done_q;
  logic             settled;
  logic [1:0]       col_idx;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] coord_q, coord_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;

  logic [4:0] low_cnt;
  logic [7:0] res_code;
  logic       res_none;
  logic       res_one;

  assign settled = (dwell_q == DWELL_MAX);

  always_comb begin
    case (col_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Rows are sampled only at the end of the dwell so the column drive has settled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      dwell_q     <= '0;
      col_q       <= 4'b1110;
      scan_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) cap_q[i] <= 4'hF;
    end else begin
      row_meta_q  <= row_in;
      row_sync_q  <= row_meta_q;
      scan_done_q <= settled && (col_q == 4'b0111);
      if (settled) begin
        dwell_q        <= '0;
        col_q          <= {col_q[2:0], col_q[3]};
        cap_q[col_idx] <= row_sync_q;
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

  always_comb begin
    low_cnt  = '0;
    res_code = NO_KEY;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!cap_q[c][r]) begin
          low_cnt  = low_cnt + 5'd1;
          res_code = {cap_q[c], 4'b1111 ^ (4'b0001 << c)};
        end
      end
    end
    res_none = (low_cnt == 5'd0);
    res_one  = (low_cnt == 5'd1);
  end

  // Multi-key scans fall through the guard and leave all debounce state untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    coord_d = coord_q;
    valid_d = 1'b0;
    if (scan_done_q && (res_none || res_one)) begin
      case (state_q)
        IDLE: begin
          if (res_one) begin
            if (DB_N == 4'd1) begin
              state_d = PRESSED;
              coord_d = res_code;
              valid_d = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = PRESS_DB;
              cand_d  = res_code;
              cnt_d   = 4'd1;
            end
          end
        end
        PRESS_DB: begin
          if (res_none) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (res_code == cand_q) begin
            if (cnt_q + 4'd1 >= DB_N) begin
              state_d = PRESSED;
              coord_d = cand_q;
              valid_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cand_d = res_code;
            cnt_d  = 4'd1;
          end
        end
        PRESSED: begin
          if (res_none || res_code != coord_q) begin
            if (DB_N == 4'd1) begin
              state_d = IDLE;
              coord_d = NO_KEY;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE_DB;
              cnt_d   = 4'd1;
            end
          end
        end
        RELEASE_DB: begin
          if (res_one && res_code == coord_q) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q + 4'd1 >= DB_N) begin
            state_d = IDLE;
            coord_d = NO_KEY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    held_d = (state_d == PRESSED) || (state_d == RELEASE_DB);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= NO_KEY;
      coord_q <= NO_KEY;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      coord_q <= coord_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign col_out   = col_q;
  assign key_coord = coord_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix model drives row_in from col_out; accepted
// presses are scoreboarded and the column rotation is watched throughout.
module tb_keypad_scanner;

  localparam int SD      = 4;
  localparam int DB      = 2;
  localparam int SCAN    = 4 * SD;
  localparam int LAT_MAX = (DB + 1) * 4 * SD + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] key_coord;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_valid = 0;
  logic        rst_at_edge = 1'b1;
  logic [3:0]  prev_col;
  int          run_len = 0;
  int          cyc;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_coord(key_coord),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Key (r,c) shorts row r to column c; rows are pulled high otherwise.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) chk("valid_expected", 32'(exp_q.size()), 32'd1);
      else chk("valid_coord", {24'd0, key_coord}, {24'd0, exp_q.pop_front()});
    end
  end

  always @(posedge clk) rst_at_edge <= ~rst_n;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      prev_col = col_out;
      run_len  = 1;
    end else if (col_out !== prev_col) begin
      chk("col_dwell", 32'(run_len), 32'(SD));
      chk("col_rotate", {28'd0, col_out}, {28'd0, prev_col[2:0], prev_col[3]});
      chk("col_onehot", 32'($countones(~col_out)), 32'd1);
      prev_col = col_out;
      run_len  = 1;
    end else begin
      run_len++;
      if (run_len > SD) chk("col_stuck", 32'(run_len), 32'(SD));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align_scan();
    int t = 0;
    while (col_out !== 4'b0111 && t < 64) begin @(negedge clk); t++; end
    while (col_out !== 4'b1110 && t < 128) begin @(negedge clk); t++; end
    chk("align_col0", {28'd0, col_out}, 32'h0000000E);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_coord"}, {24'd0, key_coord}, 32'h000000FF);
    chk({tag, "_held"}, {31'd0, key_held}, 32'd0);
  endtask

  initial begin
    tick(3);
    chk_idle("reset");
    chk("reset_valid", {31'd0, key_valid}, 32'd0);
    chk("reset_col", {28'd0, col_out}, 32'h0000000E);
    rst_n = 1'b1;
    tick(5);

    // Stable press of row0/col0.
    keys[0] = 1'b1;
    exp_q.push_back(8'hEE);
    wait_valid(cyc);
    chk("press_latency", {31'd0, cyc <= LAT_MAX}, 32'd1);
    tick(2 * SCAN);
    chk("press_coord", {24'd0, key_coord}, 32'h000000EE);
    chk("press_held", {31'd0, key_held}, 32'd1);
    chk("press_drained", 32'(exp_q.size()), 32'd0);

    // Release: one NONE scan is not enough, two are.
    keys = '0;
    tick(SCAN);
    chk("release_db_held", {31'd0, key_held}, 32'd1);
    tick(3 * SCAN);
    chk_idle("released");

    // Bounce: one scan pressed, one scan open, then stable.
    align_scan();
    keys[13] = 1'b1;
    tick(SCAN);
    keys = '0;
    tick(SCAN);
    keys[13] = 1'b1;
    exp_q.push_back(8'h7D);
    tick(4 * SCAN);
    chk("bounce_coord", {24'd0, key_coord}, 32'h0000007D);
    chk("bounce_held", {31'd0, key_held}, 32'd1);
    keys = '0;
    tick(4 * SCAN);
    chk_idle("bounce_rel");

    // Two keys at once never accepted.
    keys[0] = 1'b1;
    keys[6] = 1'b1;
    tick(6 * SCAN);
    chk_idle("multi");
    keys = '0;
    tick(2 * SCAN);

    // Reset while row3/col3 is held, then re-acceptance.
    keys[15] = 1'b1;
    exp_q.push_back(8'h77);
    tick(4 * SCAN);
    chk("r3c3_coord", {24'd0, key_coord}, 32'h00000077);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk_idle("midrst");
    chk("midrst_valid", {31'd0, key_valid}, 32'd0);
    chk("midrst_col", {28'd0, col_out}, 32'h0000000E);
    exp_q.push_back(8'h77);
    wait_valid(cyc);
    chk("rst_repress_latency", {31'd0, (cyc >= 20) && (cyc <= LAT_MAX)}, 32'd1);
    tick(SCAN);
    chk("repress_coord", {24'd0, key_coord}, 32'h00000077);
    chk("repress_held", {31'd0, key_held}, 32'd1);
    keys = '0;
    tick(4 * SCAN);
    chk_idle("final");

    chk("valid_pulses", 32'(n_valid), 32'd4);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
